// File: rtl/cpu_pipeline_regs_if.sv
// Signal bundle between the pipeline datapaths and the IF/ID, ID/EX, EX/MEM register bank.
// The master drives every _i field and observes every _o field; the register bank is the slave.
interface cpu_pipeline_regs_if;
    logic [63:0] ifde_pc_i;
    logic [63:0] ifde_pc_o;
    logic [31:0] ifde_inst_i;
    logic [31:0] ifde_inst_o;

    logic [63:0] idex_rdata1_i;
    logic [63:0] idex_rdata1_o;
    logic [63:0] idex_rdata2_i;
    logic [63:0] idex_rdata2_o;
    logic [63:0] idex_imm_i;
    logic [63:0] idex_imm_o;
    logic [63:0] idex_pc_i;
    logic [63:0] idex_pc_o;
    logic [4:0]  idex_rd_i;
    logic [4:0]  idex_rd_o;
    logic [4:0]  idex_rn_i;
    logic [4:0]  idex_rn_o;
    logic [4:0]  idex_rm_i;
    logic [4:0]  idex_rm_o;
    logic [11:0] idex_ctrl_i;
    logic [11:0] idex_ctrl_o;

    logic [63:0] exmem_alu_i;
    logic [63:0] exmem_alu_o;
    logic [63:0] exmem_sdata_i;
    logic [63:0] exmem_sdata_o;
    logic [4:0]  exmem_rd_i;
    logic [4:0]  exmem_rd_o;
    logic [2:0]  exmem_flags_i;
    logic [2:0]  exmem_flags_o;
    logic [6:0]  exmem_ctrl_i;
    logic [6:0]  exmem_ctrl_o;
    logic [63:0] exmem_target_i;
    logic [63:0] exmem_target_o;

    modport master (
        output ifde_pc_i, ifde_inst_i,
        output idex_rdata1_i, idex_rdata2_i, idex_imm_i, idex_pc_i,
        output idex_rd_i, idex_rn_i, idex_rm_i, idex_ctrl_i,
        output exmem_alu_i, exmem_sdata_i, exmem_rd_i, exmem_flags_i,
        output exmem_ctrl_i, exmem_target_i,
        input  ifde_pc_o, ifde_inst_o,
        input  idex_rdata1_o, idex_rdata2_o, idex_imm_o, idex_pc_o,
        input  idex_rd_o, idex_rn_o, idex_rm_o, idex_ctrl_o,
        input  exmem_alu_o, exmem_sdata_o, exmem_rd_o, exmem_flags_o,
        input  exmem_ctrl_o, exmem_target_o
    );

    modport slave (
        input  ifde_pc_i, ifde_inst_i,
        input  idex_rdata1_i, idex_rdata2_i, idex_imm_i, idex_pc_i,
        input  idex_rd_i, idex_rn_i, idex_rm_i, idex_ctrl_i,
        input  exmem_alu_i, exmem_sdata_i, exmem_rd_i, exmem_flags_i,
        input  exmem_ctrl_i, exmem_target_i,
        output ifde_pc_o, ifde_inst_o,
        output idex_rdata1_o, idex_rdata2_o, idex_imm_o, idex_pc_o,
        output idex_rd_o, idex_rn_o, idex_rm_o, idex_ctrl_o,
        output exmem_alu_o, exmem_sdata_o, exmem_rd_o, exmem_flags_o,
        output exmem_ctrl_o, exmem_target_o
    );
endinterface

// File: rtl/cpu_pipeline_regs.sv
// IF/ID, ID/EX and EX/MEM pipeline registers: three independent one-cycle copies, no stall/flush.
// Reset clears everything to zero, which is the bubble encoding for every downstream stage.
module cpu_pipeline_regs (
    input  logic                clk,
    input  logic                reset,
    cpu_pipeline_regs_if.slave  bus
);
    logic [63:0] ifde_pc_d,      ifde_pc_q;
    logic [31:0] ifde_inst_d,    ifde_inst_q;

    logic [63:0] idex_rdata1_d,  idex_rdata1_q;
    logic [63:0] idex_rdata2_d,  idex_rdata2_q;
    logic [63:0] idex_imm_d,     idex_imm_q;
    logic [63:0] idex_pc_d,      idex_pc_q;
    logic [4:0]  idex_rd_d,      idex_rd_q;
    logic [4:0]  idex_rn_d,      idex_rn_q;
    logic [4:0]  idex_rm_d,      idex_rm_q;
    logic [11:0] idex_ctrl_d,    idex_ctrl_q;

    logic [63:0] exmem_alu_d,    exmem_alu_q;
    logic [63:0] exmem_sdata_d,  exmem_sdata_q;
    logic [4:0]  exmem_rd_d,     exmem_rd_q;
    logic [2:0]  exmem_flags_d,  exmem_flags_q;
    logic [6:0]  exmem_ctrl_d,   exmem_ctrl_q;
    logic [63:0] exmem_target_d, exmem_target_q;

    // Next state is the raw input: values, including X/Z, pass through untouched.
    always_comb begin
        ifde_pc_d      = bus.ifde_pc_i;
        ifde_inst_d    = bus.ifde_inst_i;
        idex_rdata1_d  = bus.idex_rdata1_i;
        idex_rdata2_d  = bus.idex_rdata2_i;
        idex_imm_d     = bus.idex_imm_i;
        idex_pc_d      = bus.idex_pc_i;
        idex_rd_d      = bus.idex_rd_i;
        idex_rn_d      = bus.idex_rn_i;
        idex_rm_d      = bus.idex_rm_i;
        idex_ctrl_d    = bus.idex_ctrl_i;
        exmem_alu_d    = bus.exmem_alu_i;
        exmem_sdata_d  = bus.exmem_sdata_i;
        exmem_rd_d     = bus.exmem_rd_i;
        exmem_flags_d  = bus.exmem_flags_i;
        exmem_ctrl_d   = bus.exmem_ctrl_i;
        exmem_target_d = bus.exmem_target_i;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ifde_pc_q   <= '0;
            ifde_inst_q <= '0;
        end else begin
            ifde_pc_q   <= ifde_pc_d;
            ifde_inst_q <= ifde_inst_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idex_rdata1_q <= '0;
            idex_rdata2_q <= '0;
            idex_imm_q    <= '0;
            idex_pc_q     <= '0;
            idex_rd_q     <= '0;
            idex_rn_q     <= '0;
            idex_rm_q     <= '0;
            idex_ctrl_q   <= '0;
        end else begin
            idex_rdata1_q <= idex_rdata1_d;
            idex_rdata2_q <= idex_rdata2_d;
            idex_imm_q    <= idex_imm_d;
            idex_pc_q     <= idex_pc_d;
            idex_rd_q     <= idex_rd_d;
            idex_rn_q     <= idex_rn_d;
            idex_rm_q     <= idex_rm_d;
            idex_ctrl_q   <= idex_ctrl_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exmem_alu_q    <= '0;
            exmem_sdata_q  <= '0;
            exmem_rd_q     <= '0;
            exmem_flags_q  <= '0;
            exmem_ctrl_q   <= '0;
            exmem_target_q <= '0;
        end else begin
            exmem_alu_q    <= exmem_alu_d;
            exmem_sdata_q  <= exmem_sdata_d;
            exmem_rd_q     <= exmem_rd_d;
            exmem_flags_q  <= exmem_flags_d;
            exmem_ctrl_q   <= exmem_ctrl_d;
            exmem_target_q <= exmem_target_d;
        end
    end

    assign bus.ifde_pc_o      = ifde_pc_q;
    assign bus.ifde_inst_o    = ifde_inst_q;
    assign bus.idex_rdata1_o  = idex_rdata1_q;
    assign bus.idex_rdata2_o  = idex_rdata2_q;
    assign bus.idex_imm_o     = idex_imm_q;
    assign bus.idex_pc_o      = idex_pc_q;
    assign bus.idex_rd_o      = idex_rd_q;
    assign bus.idex_rn_o      = idex_rn_q;
    assign bus.idex_rm_o      = idex_rm_q;
    assign bus.idex_ctrl_o    = idex_ctrl_q;
    assign bus.exmem_alu_o    = exmem_alu_q;
    assign bus.exmem_sdata_o  = exmem_sdata_q;
    assign bus.exmem_rd_o     = exmem_rd_q;
    assign bus.exmem_flags_o  = exmem_flags_q;
    assign bus.exmem_ctrl_o   = exmem_ctrl_q;
    assign bus.exmem_target_o = exmem_target_q;
endmodule

// File: tb/tb_cpu_pipeline_regs.sv
// Bench for cpu_pipeline_regs: a history-queue model of "output = last input captured since reset"
// checked every falling edge, plus directed literal checks of reset, capture, isolation and streaming.
module tb_cpu_pipeline_regs;
    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    cpu_pipeline_regs_if bus();

    cpu_pipeline_regs dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Packed views of each group, inputs and outputs in the same field order.
    function automatic logic [95:0] ifde_in();
        return {bus.ifde_pc_i, bus.ifde_inst_i};
    endfunction
    function automatic logic [95:0] ifde_out();
        return {bus.ifde_pc_o, bus.ifde_inst_o};
    endfunction
    function automatic logic [282:0] idex_in();
        return {bus.idex_rdata1_i, bus.idex_rdata2_i, bus.idex_imm_i, bus.idex_pc_i,
                bus.idex_rd_i, bus.idex_rn_i, bus.idex_rm_i, bus.idex_ctrl_i};
    endfunction
    function automatic logic [282:0] idex_out();
        return {bus.idex_rdata1_o, bus.idex_rdata2_o, bus.idex_imm_o, bus.idex_pc_o,
                bus.idex_rd_o, bus.idex_rn_o, bus.idex_rm_o, bus.idex_ctrl_o};
    endfunction
    function automatic logic [206:0] exmem_in();
        return {bus.exmem_alu_i, bus.exmem_sdata_i, bus.exmem_rd_i, bus.exmem_flags_i,
                bus.exmem_ctrl_i, bus.exmem_target_i};
    endfunction
    function automatic logic [206:0] exmem_out();
        return {bus.exmem_alu_o, bus.exmem_sdata_o, bus.exmem_rd_o, bus.exmem_flags_o,
                bus.exmem_ctrl_o, bus.exmem_target_o};
    endfunction

    // Model: each group shows the most recent input captured since reset, or zero if none.
    logic [95:0]  ifde_hist[$];
    logic [282:0] idex_hist[$];
    logic [206:0] exmem_hist[$];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            ifde_hist.delete();
            idex_hist.delete();
            exmem_hist.delete();
        end else begin
            ifde_hist.push_back(ifde_in());
            idex_hist.push_back(idex_in());
            exmem_hist.push_back(exmem_in());
            if (ifde_hist.size() > 4) void'(ifde_hist.pop_front());
            if (idex_hist.size() > 4) void'(idex_hist.pop_front());
            if (exmem_hist.size() > 4) void'(exmem_hist.pop_front());
        end
    end

    function automatic logic [95:0] exp_ifde();
        return (ifde_hist.size() == 0) ? 96'd0 : ifde_hist[$];
    endfunction
    function automatic logic [282:0] exp_idex();
        return (idex_hist.size() == 0) ? 283'd0 : idex_hist[$];
    endfunction
    function automatic logic [206:0] exp_exmem();
        return (exmem_hist.size() == 0) ? 207'd0 : exmem_hist[$];
    endfunction

    task automatic check(input string name, input logic [319:0] act, input logic [319:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        check("model_ifde", 320'(ifde_out()), 320'(exp_ifde()));
        check("model_idex", 320'(idex_out()), 320'(exp_idex()));
        check("model_exmem", 320'(exmem_out()), 320'(exp_exmem()));
    end

    task automatic rand_all();
        bus.ifde_pc_i      = {$urandom, $urandom} | 64'h1;
        bus.ifde_inst_i    = $urandom | 32'h1;
        bus.idex_rdata1_i  = {$urandom, $urandom} | 64'h1;
        bus.idex_rdata2_i  = {$urandom, $urandom} | 64'h1;
        bus.idex_imm_i     = {$urandom, $urandom} | 64'h1;
        bus.idex_pc_i      = {$urandom, $urandom} | 64'h1;
        bus.idex_rd_i      = 5'($urandom_range(1, 31));
        bus.idex_rn_i      = 5'($urandom_range(1, 31));
        bus.idex_rm_i      = 5'($urandom_range(1, 31));
        bus.idex_ctrl_i    = 12'($urandom_range(1, 4095));
        bus.exmem_alu_i    = {$urandom, $urandom} | 64'h1;
        bus.exmem_sdata_i  = {$urandom, $urandom} | 64'h1;
        bus.exmem_rd_i     = 5'($urandom_range(1, 31));
        bus.exmem_flags_i  = 3'($urandom_range(1, 7));
        bus.exmem_ctrl_i   = 7'($urandom_range(1, 127));
        bus.exmem_target_i = {$urandom, $urandom} | 64'h1;
    endtask

    task automatic zero_all();
        bus.ifde_pc_i      = '0;
        bus.ifde_inst_i    = '0;
        bus.idex_rdata1_i  = '0;
        bus.idex_rdata2_i  = '0;
        bus.idex_imm_i     = '0;
        bus.idex_pc_i      = '0;
        bus.idex_rd_i      = '0;
        bus.idex_rn_i      = '0;
        bus.idex_rm_i      = '0;
        bus.idex_ctrl_i    = '0;
        bus.exmem_alu_i    = '0;
        bus.exmem_sdata_i  = '0;
        bus.exmem_rd_i     = '0;
        bus.exmem_flags_i  = '0;
        bus.exmem_ctrl_i   = '0;
        bus.exmem_target_i = '0;
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_ifde"}, 320'(ifde_out()), 320'd0);
        check({name, "_idex"}, 320'(idex_out()), 320'd0);
        check({name, "_exmem"}, 320'(exmem_out()), 320'd0);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        zero_all();
        repeat (2) @(negedge clk);
        check_all_zero("por");
        reset = 1'b0;

        // Random traffic, then asynchronous reset between edges.
        repeat (6) begin
            @(negedge clk);
            rand_all();
        end
        @(posedge clk);
        #2 reset = 1'b1;
        #1 check_all_zero("rst_async");
        repeat (3) begin
            @(negedge clk);
            rand_all();
            @(posedge clk);
            #1 check_all_zero("rst_hold");
        end

        // Single-cycle capture, unchanged before the edge.
        @(negedge clk);
        reset = 1'b0;
        zero_all();
        bus.ifde_pc_i   = 64'h40;
        bus.ifde_inst_i = 32'h8B02_0020;
        #1 check("cap_pc_before", 320'(bus.ifde_pc_o), 320'd0);
        @(posedge clk);
        #1 check("cap_pc", 320'(bus.ifde_pc_o), 320'h40);
        check("cap_inst", 320'(bus.ifde_inst_o), 320'h8B02_0020);

        // Full-width ID/EX patterns, then all zeros.
        @(negedge clk);
        bus.idex_rdata1_i = 64'hFFFF_FFFF_FFFF_FFFF;
        bus.idex_imm_i    = 64'h8000_0000_0000_0000;
        bus.idex_rd_i     = 5'd31;
        bus.idex_ctrl_i   = 12'hFFF;
        @(posedge clk);
        #1 check("full_rdata1", 320'(bus.idex_rdata1_o), 320'hFFFF_FFFF_FFFF_FFFF);
        check("full_imm", 320'(bus.idex_imm_o), 320'h8000_0000_0000_0000);
        check("full_rd", 320'(bus.idex_rd_o), 320'd31);
        check("full_ctrl", 320'(bus.idex_ctrl_o), 320'hFFF);
        @(negedge clk);
        bus.idex_rdata1_i = '0;
        bus.idex_imm_i    = '0;
        bus.idex_rd_i     = '0;
        bus.idex_ctrl_i   = '0;
        @(posedge clk);
        #1 check("zero_idex", 320'(idex_out()), 320'd0);

        // Only EX/MEM inputs change.
        @(negedge clk);
        bus.exmem_alu_i    = 64'h1234;
        bus.exmem_target_i = 64'h100;
        bus.exmem_flags_i  = 3'b101;
        bus.exmem_ctrl_i   = 7'b1001000;
        @(posedge clk);
        #1 check("iso_alu", 320'(bus.exmem_alu_o), 320'h1234);
        check("iso_target", 320'(bus.exmem_target_o), 320'h100);
        check("iso_flags", 320'(bus.exmem_flags_o), 320'b101);
        check("iso_ctrl", 320'(bus.exmem_ctrl_o), 320'b1001000);
        check("iso_ifde", 320'(ifde_out()), {224'd0, 64'h40, 32'h8B02_0020});
        check("iso_idex", 320'(idex_out()), 320'd0);

        // Back-to-back PC stream.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.ifde_pc_i = 64'(4 * i);
            @(posedge clk);
            #1 check("stream_pc", 320'(bus.ifde_pc_o), 320'(4 * i));
        end

        // 1 ns reset pulse mid-stream; the next edge reloads the held inputs.
        #1 reset = 1'b1;
        #0.5 check_all_zero("pulse");
        #0.5 reset = 1'b0;
        #1 check_all_zero("pulse_after");
        @(posedge clk);
        #1 check("reload_pc", 320'(bus.ifde_pc_o), 320'd16);
        check("reload_inst", 320'(bus.ifde_inst_o), 320'h8B02_0020);
        check("reload_alu", 320'(bus.exmem_alu_o), 320'h1234);

        // Random streaming with the model as reference.
        repeat (20) begin
            @(negedge clk);
            rand_all();
        end
        repeat (2) @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
